// File: rtl/dram_pkg.sv
// dram_pkg: shared DRAM word layout, diagnostic function codes, FSM states and parity helper.
package dram_pkg;
   localparam int DRAM_ADDR_BITS = 9;
   localparam int DRAM_WIDTH = 15;
   typedef struct packed {
      logic [2:0] a;
      logic [2:0] b;
      logic       p;
      logic [3:0] jh;
      logic [3:0] jl;
   } dram_word_t;
   localparam logic [2:0] DIAG_LDADR  = 3'd0;
   localparam logic [2:0] DIAG_LDAB   = 3'd1;
   localparam logic [2:0] DIAG_LDJH   = 3'd2;
   localparam logic [2:0] DIAG_LDJL   = 3'd3;
   localparam logic [2:0] DIAG_COMMIT = 3'd4;
   localparam logic [2:0] DIAG_READ   = 3'd5;
   localparam logic [2:0] DIAG_CLRERR = 3'd6;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAITW = 3'd1;
   localparam logic [2:0] S_WAITV = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_WAITR = 3'd4;
   localparam logic [2:0] S_RDCAP = 3'd5;
   // P makes the whole 15-bit word odd parity
   function automatic logic dram_par(input dram_word_t w);
      return ~^{w.a, w.b, w.jh, w.jl};
   endfunction
endpackage

// File: rtl/dram_port_arb.sv
// dram_port_arb: single DRAM port mux; an EBOX IR-load read always wins and blocks writes.
module dram_port_arb import dram_pkg::*; #(
   parameter int ADDR_BITS = DRAM_ADDR_BITS
) (
   input  logic                 ebox_rd,
   input  logic [ADDR_BITS-1:0] ebox_addr,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic                 we_req,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_we
);
   assign mem_addr = ebox_rd ? ebox_addr : addr;
   assign mem_we = we_req & ~ebox_rd;
endmodule

// File: rtl/dram_load_ctl.sv
// dram_load_ctl: diagnostic DRAM loader; stages fields, writes with parity, verifies by
// read-back with bounded retry, and gives up if the EBOX starves the port too long.
module dram_load_ctl import dram_pkg::*; #(
   parameter int ADDR_BITS  = DRAM_ADDR_BITS,
   parameter int DRAM_WIDTH = dram_pkg::DRAM_WIDTH,
   parameter int RETRY_MAX  = 3,
   parameter int STARVE_MAX = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  diag_strobe,
   input  logic [2:0]            diag_func,
   input  logic [ADDR_BITS-1:0]  diag_data,
   input  logic                  ebox_rd,
   input  logic [ADDR_BITS-1:0]  ebox_addr,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [DRAM_WIDTH-1:0] mem_din,
   output logic                  mem_we,
   input  logic [DRAM_WIDTH-1:0] mem_dout,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DRAM_WIDTH-1:0] rd_data
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int RW = $clog2(RETRY_MAX + 1);
   logic [2:0] state;
   dram_word_t stage;
   logic [ADDR_BITS-1:0] addr;
   logic [RW-1:0] retry;
   logic [SW-1:0] starve;
   logic starved, match, we_req;
   assign busy = state != S_IDLE;
   assign we_req = state == S_WAITW;
   assign starved = starve >= SW'(STARVE_MAX - 1);
   assign match = mem_dout == stage;
   assign mem_din = stage;
   dram_port_arb #(.ADDR_BITS(ADDR_BITS)) u_arb (
      .ebox_rd(ebox_rd),
      .ebox_addr(ebox_addr),
      .addr(addr),
      .we_req(we_req),
      .mem_addr(mem_addr),
      .mem_we(mem_we)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         stage <= '0;
         addr <= '0;
         retry <= '0;
         starve <= '0;
         rd_data <= '0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         done <= 1'b0;
         if (diag_strobe && diag_func == DIAG_CLRERR) err <= 1'b0;
         case (state)
            S_IDLE:
               if (diag_strobe)
                  case (diag_func)
                     DIAG_LDADR: addr <= diag_data;
                     DIAG_LDAB: {stage.a, stage.b} <= diag_data[8:3];
                     DIAG_LDJH: stage.jh <= diag_data[8:5];
                     DIAG_LDJL: stage.jl <= diag_data[8:5];
                     DIAG_COMMIT: begin
                        stage.p <= dram_par(stage);
                        retry <= '0;
                        starve <= '0;
                        state <= S_WAITW;
                     end
                     DIAG_READ: begin
                        starve <= '0;
                        state <= S_WAITR;
                     end
                     default: ;
                  endcase
            S_WAITW, S_WAITV, S_WAITR:
               if (!ebox_rd) begin
                  starve <= '0;
                  state <= state == S_WAITW ? S_WAITV : state == S_WAITV ? S_CHECK : S_RDCAP;
               end else if (starved) begin
                  err <= 1'b1;
                  state <= S_IDLE;
               end else starve <= starve + 1'b1;
            // mem_dout holds the word read in WAITV, so ebox_rd no longer matters here
            S_CHECK:
               if (match) begin
                  rd_data <= mem_dout;
                  done <= 1'b1;
                  state <= S_IDLE;
               end else if (int'(retry) + 1 < RETRY_MAX) begin
                  retry <= retry + 1'b1;
                  state <= S_WAITW;
               end else begin
                  rd_data <= mem_dout;
                  err <= 1'b1;
                  state <= S_IDLE;
               end
            S_RDCAP: begin
               rd_data <= mem_dout;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dram_load_ctl.sv
// tb_dram_load_ctl: table-driven commits plus scoreboarded write/verify, retry, starvation,
// busy-lockout, read and reset sequences against a behavioural DRAM model.
module tb_dram_load_ctl;
   logic clk = 1'b0, rst_n = 1'b0, diag_strobe = 1'b0, ebox_rd = 1'b0;
   logic [2:0] diag_func = '0;
   logic [8:0] diag_data = '0, ebox_addr = '0, mem_addr;
   logic [14:0] mem_din, mem_dout, rd_data;
   logic mem_we, busy, done, err;
   int checks = 0, failures = 0, corrupt_n = 0;
   typedef struct {logic [8:0] addr; logic [14:0] din;} wr_t;
   typedef struct {logic done; logic err; logic [14:0] rd;} res_t;
   typedef struct {logic [8:0] addr; logic [2:0] a; logic [2:0] b; logic [3:0] jh; logic [3:0] jl; logic [14:0] word;} vec_t;
   wr_t wr_q[$];
   res_t res_q[$];
   wr_t w;
   res_t r;
   vec_t vecs[5];
   logic [14:0] mem [512];
   logic we_d = 1'b0, mon_en = 1'b0, busy_prev = 1'b0;
   always #5 clk = ~clk;
   dram_load_ctl dut (
      .clk(clk), .rst_n(rst_n), .diag_strobe(diag_strobe), .diag_func(diag_func),
      .diag_data(diag_data), .ebox_rd(ebox_rd), .ebox_addr(ebox_addr), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout), .busy(busy), .done(done),
      .err(err), .rd_data(rd_data)
   );
   // DRAM model: 1-cycle read latency; optionally corrupts the read right after a write
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      if (we_d && corrupt_n > 0) begin
         mem_dout <= mem[mem_addr] ^ 15'h1;
         corrupt_n = corrupt_n - 1;
      end else mem_dout <= mem[mem_addr];
      we_d <= mem_we;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (mon_en) begin
         if (ebox_rd) begin
            chk("ebox_no_we", mem_we, 0);
            chk("ebox_addr", mem_addr, ebox_addr);
         end
         if (mem_we) begin
            chk("write_expected", wr_q.size() > 0, 1);
            if (wr_q.size() > 0) begin
               w = wr_q.pop_front();
               chk("wr_addr", mem_addr, w.addr);
               chk("wr_din", mem_din, w.din);
            end
         end
         if (busy_prev && !busy) begin
            chk("result_expected", res_q.size() > 0, 1);
            if (res_q.size() > 0) begin
               r = res_q.pop_front();
               chk("res_done", done, r.done);
               chk("res_err", err, r.err);
               chk("res_rd_data", rd_data, r.rd);
            end
         end else if (done) chk("stray_done", done, 0);
      end
      busy_prev = busy;
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic strobe(input logic [2:0] f, input logic [8:0] d);
      diag_func = f;
      diag_data = d;
      diag_strobe = 1'b1;
      tick();
      diag_strobe = 1'b0;
   endtask
   task automatic stage_word(input vec_t v);
      strobe(3'd0, v.addr);
      strobe(3'd1, {v.a, v.b, 3'b000});
      strobe(3'd2, {v.jh, 5'b0});
      strobe(3'd3, {v.jl, 5'b0});
   endtask
   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      if (busy) chk("idle_timeout", busy, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      vecs[0] = '{9'o254, 3'd5, 3'd2, 4'hA, 4'h3, {3'd5, 3'd2, 1'b0, 4'hA, 4'h3}};
      vecs[1] = '{9'o000, 3'd0, 3'd0, 4'h0, 4'h0, {3'd0, 3'd0, 1'b1, 4'h0, 4'h0}};
      vecs[2] = '{9'o777, 3'd7, 3'd7, 4'hF, 4'hF, {3'd7, 3'd7, 1'b1, 4'hF, 4'hF}};
      vecs[3] = '{9'o001, 3'd1, 3'd0, 4'h0, 4'h0, {3'd1, 3'd0, 1'b0, 4'h0, 4'h0}};
      vecs[4] = '{9'o400, 3'd3, 3'd4, 4'h6, 4'h1, {3'd3, 3'd4, 1'b1, 4'h6, 4'h1}};
      for (int i = 0; i < 512; i++) mem[i] <= 15'h0;
      mem[9'o700] <= 15'h2B5C;
      repeat (2) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rd_data", rd_data, 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      // first commit with exact cycle-by-cycle latency
      stage_word(vecs[0]);
      wr_q.push_back(wr_t'{vecs[0].addr, vecs[0].word});
      res_q.push_back(res_t'{1'b1, 1'b0, vecs[0].word});
      strobe(3'd4, 9'd0);
      chk("lat_we", mem_we, 1);
      chk("lat_addr", mem_addr, 9'o254);
      chk("lat_din", mem_din, vecs[0].word);
      tick();
      chk("lat_waitv_we", mem_we, 0);
      chk("lat_waitv_done", done, 0);
      tick();
      chk("lat_check_done", done, 0);
      tick();
      chk("lat_done", done, 1);
      chk("lat_busy", busy, 0);
      chk("lat_rd_data", rd_data, vecs[0].word);
      for (int i = 1; i < 5; i++) begin
         stage_word(vecs[i]);
         wr_q.push_back(wr_t'{vecs[i].addr, vecs[i].word});
         res_q.push_back(res_t'{1'b1, 1'b0, vecs[i].word});
         strobe(3'd4, 9'd0);
         wait_idle(40);
         chk("mem_contents", mem[vecs[i].addr], vecs[i].word);
      end
      // EBOX holds the port for 10 cycles after COMMIT
      ebox_addr = 9'o123;
      ebox_rd = 1'b1;
      wr_q.push_back(wr_t'{9'o400, vecs[4].word});
      res_q.push_back(res_t'{1'b1, 1'b0, vecs[4].word});
      strobe(3'd4, 9'd0);
      repeat (10) tick();
      chk("stall_busy", busy, 1);
      chk("stall_no_write", wr_q.size(), 1);
      ebox_rd = 1'b0;
      wait_idle(20);
      chk("stall_err", err, 0);
      // two corrupted verifies, third attempt passes
      strobe(3'd0, 9'o055);
      corrupt_n = 2;
      repeat (3) wr_q.push_back(wr_t'{9'o055, vecs[4].word});
      res_q.push_back(res_t'{1'b1, 1'b0, vecs[4].word});
      strobe(3'd4, 9'd0);
      wait_idle(40);
      chk("retry_corrupt_used", corrupt_n, 0);
      // staging strobes while busy are ignored
      ebox_rd = 1'b1;
      wr_q.push_back(wr_t'{9'o055, vecs[4].word});
      res_q.push_back(res_t'{1'b1, 1'b0, vecs[4].word});
      strobe(3'd4, 9'd0);
      strobe(3'd1, 9'b111_111_000);
      strobe(3'd0, 9'o001);
      strobe(3'd2, 9'b1111_00000);
      ebox_rd = 1'b0;
      wait_idle(20);
      wr_q.push_back(wr_t'{9'o055, vecs[4].word});
      res_q.push_back(res_t'{1'b1, 1'b0, vecs[4].word});
      strobe(3'd4, 9'd0);
      wait_idle(20);
      // READ returns memory contents without done
      strobe(3'd0, 9'o700);
      res_q.push_back(res_t'{1'b0, 1'b0, 15'h2B5C});
      strobe(3'd5, 9'd0);
      wait_idle(20);
      // starvation: EBOX never releases the port
      ebox_rd = 1'b1;
      res_q.push_back(res_t'{1'b0, 1'b1, 15'h2B5C});
      strobe(3'd4, 9'd0);
      n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      chk("starve_cycles", n, 255);
      ebox_rd = 1'b0;
      chk("starve_err", err, 1);
      strobe(3'd6, 9'd0);
      chk("clrerr", err, 0);
      // every verify corrupted -> error with the corrupt word captured
      corrupt_n = 3;
      repeat (3) wr_q.push_back(wr_t'{9'o700, vecs[4].word});
      res_q.push_back(res_t'{1'b0, 1'b1, vecs[4].word ^ 15'h1});
      strobe(3'd4, 9'd0);
      wait_idle(40);
      chk("fail_err_sticky", err, 1);
      // reset while stalled in WAITV aborts the sequence
      wr_q.push_back(wr_t'{9'o700, vecs[4].word});
      strobe(3'd4, 9'd0);
      tick();
      chk("rst_seq_busy_pre", busy, 1);
      ebox_rd = 1'b1;
      mon_en = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("rst_seq_busy", busy, 0);
      chk("rst_seq_err", err, 0);
      chk("rst_seq_rd_data", rd_data, 0);
      rst_n = 1'b1;
      ebox_rd = 1'b0;
      repeat (4) begin
         tick();
         chk("rst_seq_no_done", done, 0);
         chk("rst_seq_idle", busy, 0);
      end
      chk("rst_seq_rd_hold", rd_data, 0);
      mon_en = 1'b1;
      tick();
      chk("wr_q_drained", wr_q.size(), 0);
      chk("res_q_drained", res_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dram_load_ctl.md
Name: dram_load_ctl

Overview:
- Diagnostic loader/sequencer for the 512x15 dispatch RAM (DRAM) feeding the IR board.
- Collects field writes from the diagnostic function path, generates the DRAM parity bit, and arbitrates the single DRAM port against EBOX IR-load reads.
- Writes the word, reads it back, and verifies it with bounded retry; a starvation timeout guards against a port that never frees up.
- Sits between the CTL diagnostic decode and the DRAM memory macro, replacing the tied-off write port.

Parameters:
- ADDR_BITS, 9, DRAM address width (512 words)
- DRAM_WIDTH, 15, word width: A[0:2], B[0:2], P, J[1:4], J[7:10]
- RETRY_MAX, 3, write+verify attempts before error
- STARVE_MAX, 255, cycles to wait for the port before error

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- diag_strobe  in  1  one-cycle diagnostic function strobe
- diag_func  in  3  function code, see Behaviour
- diag_data  in  9  function operand
- ebox_rd  in  1  EBOX needs the DRAM port this cycle (IR load)
- ebox_addr  in  9  EBOX DRAM address
- mem_addr  out  9  DRAM address
- mem_din  out  15  DRAM write data
- mem_we  out  1  DRAM write enable
- mem_dout  in  15  DRAM read data, 1-cycle latency
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when a commit verifies
- err  out  1  sticky error flag
- rd_data  out  15  last verified or read-back word

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; staging registers, rd_data, retry and starvation counters = 0.
  - busy=0, done=0, err=0, mem_we=0.
  - Reset mid-sequence aborts with no further write; a write already issued in that cycle stands.
- Clock and reset: one clock. Reset is synchronous and active-low. Ports are named clk and rst_n.
- Port arbitration (combinational):
  - ebox_rd=1 always wins: mem_addr=ebox_addr and mem_we=0.
  - Otherwise mem_addr is the staged address.
  - The controller never writes in a cycle where ebox_rd=1.
- diag_func codes, accepted only when diag_strobe=1:
  - 0 LDADR: addr <= diag_data.
  - 1 LDAB: A <= diag_data[0:2], B <= diag_data[3:5].
  - 2 LDJH: J[1:4] <= diag_data[0:3].
  - 3 LDJL: J[7:10] <= diag_data[0:3].
  - 4 COMMIT: start the write sequence.
  - 5 READ: read the word at the staged address into rd_data.
  - 6 CLRERR: err <= 0.
  - 7: ignored.
- While busy=1, strobes of codes 0-5 are ignored and do not change the staging registers. CLRERR is always honoured.
- Parity: P = ~^{A, B, J[1:4], J[7:10]}, so the 15-bit word has odd parity. P is recomputed at COMMIT. mem_din = {A, B, P, J[1:4], J[7:10]}.
- State machine:
  - IDLE: COMMIT -> WAITW with retry=0 and starve=0. READ -> WAITR with starve=0.
  - WAITW:
    - ebox_rd=0 -> assert mem_we for one cycle -> WAITV.
    - ebox_rd=1 -> starve++. When starve reaches STARVE_MAX: err=1 -> IDLE.
  - WAITV:
    - ebox_rd=0 -> issue a read (mem_we=0) -> CHECK.
    - ebox_rd=1 -> stall, with the same starvation rule as WAITW.
  - CHECK (mem_dout valid):
    - match -> rd_data <= mem_dout, done=1 -> IDLE.
    - mismatch, retry+1 < RETRY_MAX -> retry++ -> WAITW.
    - mismatch otherwise -> rd_data <= mem_dout, err=1 -> IDLE.
  - WAITR:
    - ebox_rd=0 -> read issued -> RDCAP.
    - ebox_rd=1 -> stall, with the same starvation rule as WAITW.
  - RDCAP: rd_data <= mem_dout -> IDLE. No done pulse.
- busy=1 in every state except IDLE.
- Minimum latency COMMIT -> done is 3 cycles after the strobe edge: WAITW, WAITV, CHECK.
- ebox_rd rising during CHECK or RDCAP has no effect on them: the data was captured from the earlier read cycle.
- The starvation counter restarts at 0 on every entry to a WAIT state.
- The counter saturates; it cannot wrap.
- err is sticky across commits. A new COMMIT is still accepted while err=1.

Decomposition:
- Shared package dram_pkg:
  - typedef dram_word_t as the packed 15-bit word with fields a, b, p, jh, jl.
  - DIAG function code constants.
  - DRAM_ADDR_BITS and DRAM_WIDTH.
  - Parity function dram_par(word).
- The ir block reuses dram_pkg for its field unpacking.
- One natural sub-module: dram_port_arb, the combinational EBOX-priority address/we mux.

Test Plan:
- Stage A=5, B=2, J[1:4]=0xA, J[7:10]=0x3, addr=0o254, COMMIT with ebox_rd=0 -> mem_we one cycle at addr 0o254, mem_din=0b101_010_P_1010_0011 with P making the word odd parity, done 3 cycles later, rd_data equals written word.
- ebox_rd held 1 for 10 cycles after COMMIT -> mem_we=0 throughout, mem_addr=ebox_addr, write occurs on cycle 11, done follows, err=0.
- Memory model corrupts the first two readbacks -> two rewrites, third verify passes, done=1. Corrupt all three -> err=1, no done, rd_data=corrupt value.
- ebox_rd stuck 1 for STARVE_MAX cycles -> err=1, busy=0, no write issued; CLRERR -> err=0.
- LDAB strobed while busy -> staging unchanged, verified word reflects the pre-COMMIT values; READ at addr 0o700 -> rd_data = memory contents, no done.
- rst_n=0 in WAITV -> next cycle busy=0, err=0, rd_data=0, no read or check completes.
